// File: rtl/cgra_col_mem_arbiter_pkg.sv
// Shared types and sizing for the CGRA column memory arbiter.
// Optional stall counters are enabled with CGRA_ARB_PERF_CNT_EN.
package cgra_col_mem_arbiter_pkg;

  localparam int N_COL           = 4;
  localparam int DP_WIDTH        = 32;
  localparam int ARB_OUTSTANDING = 2;
  localparam int ID_W            = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int CNT_W           = $clog2(ARB_OUTSTANDING + 1);

  typedef logic [ID_W-1:0]  col_id_t;
  typedef logic [N_COL-1:0] col_vec_t;

  typedef struct packed {
    col_id_t id;
    logic    is_read;
  } cgra_arb_id_t;

  // First requesting column at or after start, wrapping; returns start when nobody requests.
  function automatic col_id_t rr_pick(input col_vec_t req, input col_id_t start);
    col_id_t pick;
    int      idx;
    pick = start;
    for (int i = N_COL - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % N_COL;
      if (req[idx]) pick = col_id_t'(idx);
    end
    return pick;
  endfunction

  function automatic col_id_t next_col(input col_id_t c);
    return (int'(c) == N_COL - 1) ? '0 : col_id_t'(int'(c) + 1);
  endfunction

endpackage

// File: rtl/cgra_col_mem_arbiter_if.sv
// Column-side and master-side bus bundle of the arbiter; master = arbiter view.
interface cgra_col_mem_arbiter_if;
  import cgra_col_mem_arbiter_pkg::*;

  logic [N_COL-1:0]                col_req_i;
  logic [N_COL-1:0]                col_wen_i;
  logic [N_COL-1:0]                col_ind_i;
  logic [N_COL-1:0][DP_WIDTH-1:0]  col_add_i;
  logic [N_COL-1:0][DP_WIDTH-1:0]  col_wdata_i;
  logic [N_COL-1:0]                col_gnt_o;
  logic [N_COL-1:0]                col_rvalid_o;
  logic [DP_WIDTH-1:0]             col_rdata_o;
  logic [N_COL-1:0]                ptr_we_i;
  logic [N_COL-1:0][DP_WIDTH-1:0]  ptr_base_i;
  logic [N_COL-1:0][DP_WIDTH-1:0]  ptr_stride_i;
  logic                            m_req_o;
  logic                            m_gnt_i;
  logic                            m_we_o;
  logic [3:0]                      m_be_o;
  logic [DP_WIDTH-1:0]             m_addr_o;
  logic [DP_WIDTH-1:0]             m_wdata_o;
  logic                            m_rvalid_i;
  logic [DP_WIDTH-1:0]             m_rdata_i;
  logic                            busy_o;
  logic                            err_o;

  modport master (
    input  col_req_i, col_wen_i, col_ind_i, col_add_i, col_wdata_i,
           ptr_we_i, ptr_base_i, ptr_stride_i, m_gnt_i, m_rvalid_i, m_rdata_i,
    output col_gnt_o, col_rvalid_o, col_rdata_o, m_req_o, m_we_o, m_be_o,
           m_addr_o, m_wdata_o, busy_o, err_o
  );

  modport slave (
    output col_req_i, col_wen_i, col_ind_i, col_add_i, col_wdata_i,
           ptr_we_i, ptr_base_i, ptr_stride_i, m_gnt_i, m_rvalid_i, m_rdata_i,
    input  col_gnt_o, col_rvalid_o, col_rdata_o, m_req_o, m_we_o, m_be_o,
           m_addr_o, m_wdata_o, busy_o, err_o
  );

endinterface

// File: rtl/cgra_col_mem_arbiter_id_fifo.sv
// In-order FIFO of {column id, is_read} tags for issued-but-unanswered transactions.
module cgra_col_mem_arbiter_id_fifo
  import cgra_col_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_OUTSTANDING,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  cgra_arb_id_t  data_i,
  input  logic          pop_i,
  output cgra_arb_id_t  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  cgra_arb_id_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cgra_col_mem_arbiter.sv
// Round-robin share of one OBI-style master port among the CGRA column data ports.
// Define CGRA_ARB_PERF_CNT_EN to add per-column saturating stall counters (stall_cnt_o).
module cgra_col_mem_arbiter
  import cgra_col_mem_arbiter_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cgra_col_mem_arbiter_if.master bus
`ifdef CGRA_ARB_PERF_CNT_EN
  ,
  output logic [N_COL-1:0][31:0] stall_cnt_o
`endif
);

  col_id_t                        rr_q, lock_id_q, winner;
  logic                           lock_q, lock_act, grant, pop, err_q;
  logic                           fifo_full, fifo_empty;
  logic [CNT_W-1:0]               fifo_count;
  logic [N_COL-1:0][DP_WIDTH-1:0] ptr_q;
  cgra_arb_id_t                   push_data, head;

  // A stalled winner keeps the port until granted, unless its column withdraws.
  assign lock_act = lock_q & bus.col_req_i[lock_id_q];
  assign winner   = lock_act ? lock_id_q : rr_pick(bus.col_req_i, rr_q);

  assign bus.m_req_o   = rst_ni & (|bus.col_req_i) & ~fifo_full;
  assign grant         = bus.m_req_o & bus.m_gnt_i;
  assign bus.col_gnt_o = grant ? (col_vec_t'(1) << winner) : '0;
  assign bus.m_we_o    = bus.m_req_o & ~bus.col_wen_i[winner];
  assign bus.m_be_o    = 4'hF;
  assign bus.m_addr_o  = !bus.m_req_o          ? '0 :
                         bus.col_ind_i[winner] ? bus.col_add_i[winner] : ptr_q[winner];
  assign bus.m_wdata_o = bus.m_we_o ? bus.col_wdata_i[winner] : '0;

  assign push_data        = '{id: winner, is_read: bus.col_wen_i[winner]};
  assign pop              = bus.m_rvalid_i & ~fifo_empty;
  assign bus.col_rvalid_o = (pop & head.is_read) ? (col_vec_t'(1) << head.id) : '0;
  assign bus.col_rdata_o  = (pop & head.is_read) ? bus.m_rdata_i : '0;
  assign bus.busy_o       = (fifo_count != '0) | bus.m_req_o;
  assign bus.err_o        = err_q;

  cgra_col_mem_arbiter_id_fifo #(.DEPTH(ARB_OUTSTANDING)) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant) begin
        rr_q   <= next_col(winner);
        lock_q <= 1'b0;
      end else if (bus.m_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= winner;
      end else if (lock_q && !bus.col_req_i[lock_id_q]) begin
        lock_q <= 1'b0;
      end
      if (bus.m_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // A pointer load wins over the post-increment of the same column.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      for (int c = 0; c < N_COL; c++) begin
        if (bus.ptr_we_i[c]) begin
          ptr_q[c] <= bus.ptr_base_i[c];
        end else if (grant && winner == col_id_t'(c) && !bus.col_ind_i[c]) begin
          ptr_q[c] <= ptr_q[c] + bus.ptr_stride_i[c];
        end
      end
    end
  end

`ifdef CGRA_ARB_PERF_CNT_EN
  logic [N_COL-1:0][31:0] stall_q;

  assign stall_cnt_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      for (int c = 0; c < N_COL; c++) begin
        if (bus.ptr_we_i[c]) begin
          stall_q[c] <= '0;
        end else if (bus.col_req_i[c] && !bus.col_gnt_o[c] && stall_q[c] != '1) begin
          stall_q[c] <= stall_q[c] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cgra_col_mem_arbiter.sv
// Self-checking bench for cgra_col_mem_arbiter: directed scenarios, then random traffic vs a queue model.
module tb_cgra_col_mem_arbiter;
  import cgra_col_mem_arbiter_pkg::*;

  typedef struct {
    int id;
    bit is_read;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cgra_col_mem_arbiter_if bif ();

`ifdef CGRA_ARB_PERF_CNT_EN
  logic [N_COL-1:0][31:0] stall_cnt;
  logic [31:0]            model_stall [N_COL];
`endif

  cgra_col_mem_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif)
`ifdef CGRA_ARB_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference state: round-robin start, held (stalled) winner, pointers, outstanding tags.
  int          model_rr   = 0;
  bit          hold_valid = 0;
  int          hold_id    = 0;
  logic [31:0] model_ptr [N_COL];
  resp_t       model_q [$];
  bit          model_err  = 0;
  logic [N_COL-1:0] last_gnt = '0;

  int          exp_w;
  logic        exp_mreq, exp_we, exp_busy, exp_err;
  logic [N_COL-1:0] exp_gnt, exp_rvalid;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void compute_expect();
    int n_out = model_q.size();
    exp_w = 0;
    if (hold_valid && bif.col_req_i[hold_id]) begin
      exp_w = hold_id;
    end else begin
      for (int k = 0; k < N_COL; k++) begin
        if (bif.col_req_i[(model_rr + k) % N_COL]) begin
          exp_w = (model_rr + k) % N_COL;
          break;
        end
      end
    end
    exp_mreq   = rst_n && (bif.col_req_i != '0) && (n_out < ARB_OUTSTANDING);
    exp_gnt    = (exp_mreq && bif.m_gnt_i) ? (N_COL'(1) << exp_w) : '0;
    exp_we     = exp_mreq && !bif.col_wen_i[exp_w];
    exp_addr   = !exp_mreq ? 32'h0 : (bif.col_ind_i[exp_w] ? bif.col_add_i[exp_w] : model_ptr[exp_w]);
    exp_wdata  = exp_we ? bif.col_wdata_i[exp_w] : 32'h0;
    exp_rvalid = '0;
    exp_rdata  = 32'h0;
    if (rst_n && bif.m_rvalid_i && n_out > 0 && model_q[0].is_read) begin
      exp_rvalid = N_COL'(1) << model_q[0].id;
      exp_rdata  = bif.m_rdata_i;
    end
    exp_busy = (n_out > 0) || exp_mreq;
    exp_err  = model_err;
  endfunction

  // Model advances on each clock edge using the inputs that were present before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_rr = 0; hold_valid = 0; hold_id = 0; model_err = 0;
      model_q.delete();
      for (int c = 0; c < N_COL; c++) model_ptr[c] = 32'h0;
`ifdef CGRA_ARB_PERF_CNT_EN
      for (int c = 0; c < N_COL; c++) model_stall[c] = 32'h0;
`endif
    end else begin
      resp_t tag;
      compute_expect();
      if (bif.m_rvalid_i) begin
        if (model_q.size() > 0) void'(model_q.pop_front());
        else model_err = 1;
      end
      if (exp_gnt != '0) begin
        tag.id = exp_w;
        tag.is_read = bif.col_wen_i[exp_w];
        model_q.push_back(tag);
        model_rr = (exp_w + 1) % N_COL;
        if (!bif.col_ind_i[exp_w]) model_ptr[exp_w] = model_ptr[exp_w] + bif.ptr_stride_i[exp_w];
        hold_valid = 0;
      end else if (exp_mreq) begin
        hold_valid = 1;
        hold_id    = exp_w;
      end else if (hold_valid && !bif.col_req_i[hold_id]) begin
        hold_valid = 0;
      end
      for (int c = 0; c < N_COL; c++) begin
        if (bif.ptr_we_i[c]) model_ptr[c] = bif.ptr_base_i[c];
`ifdef CGRA_ARB_PERF_CNT_EN
        if (bif.ptr_we_i[c]) model_stall[c] = 32'h0;
        else if (bif.col_req_i[c] && !exp_gnt[c] && model_stall[c] != 32'hFFFF_FFFF)
          model_stall[c] = model_stall[c] + 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    compute_expect();
    check_output("m_req",      bif.m_req_o,      exp_mreq);
    check_output("col_gnt",    bif.col_gnt_o,    exp_gnt);
    check_output("m_we",       bif.m_we_o,       exp_we);
    check_output("m_addr",     bif.m_addr_o,     exp_addr);
    check_output("m_wdata",    bif.m_wdata_o,    exp_wdata);
    check_output("m_be",       bif.m_be_o,       4'hF);
    check_output("col_rvalid", bif.col_rvalid_o, exp_rvalid);
    check_output("col_rdata",  bif.col_rdata_o,  exp_rdata);
    check_output("busy",       bif.busy_o,       exp_busy);
    check_output("err",        bif.err_o,        exp_err);
`ifdef CGRA_ARB_PERF_CNT_EN
    for (int c = 0; c < N_COL; c++) check_output("stall_cnt", stall_cnt[c], model_stall[c]);
`endif
    last_gnt = bif.col_gnt_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive_col(input int c, input bit req, input bit rd, input bit ind,
                           input logic [31:0] add, input logic [31:0] wdata);
    bif.col_req_i[c]   = req;
    bif.col_wen_i[c]   = rd;
    bif.col_ind_i[c]   = ind;
    bif.col_add_i[c]   = add;
    bif.col_wdata_i[c] = wdata;
  endtask

  task automatic apply_stimulus(input bit gnt, input bit rvalid, input logic [31:0] rdata);
    bif.m_gnt_i    = gnt;
    bif.m_rvalid_i = rvalid;
    bif.m_rdata_i  = rdata;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    bif.col_req_i = '0; bif.col_wen_i = '0; bif.col_ind_i = '0;
    bif.col_add_i = '0; bif.col_wdata_i = '0;
    bif.ptr_we_i = '0; bif.ptr_base_i = '0; bif.ptr_stride_i = '0;
    apply_stimulus(0, 0, 32'h0);

    step(); step();
    check_output("rst_m_req",  bif.m_req_o,     1'b0);
    check_output("rst_gnt",    bif.col_gnt_o,   4'b0000);
    check_output("rst_busy",   bif.busy_o,      1'b0);
    check_output("rst_err",    bif.err_o,       1'b0);
    rst_n = 1'b1;

    $display("[TB] single indirect read by column 2");
    step();
    drive_col(2, 1, 1, 1, 32'h100, 32'h0);
    apply_stimulus(1, 0, 32'h0);
    settle();
    check_output("t1_gnt",  bif.col_gnt_o, 4'b0100);
    check_output("t1_addr", bif.m_addr_o,  32'h100);
    step();
    drive_col(2, 0, 1, 1, 32'h100, 32'h0);
    apply_stimulus(0, 1, 32'hDEAD);
    settle();
    check_output("t1_rvalid", bif.col_rvalid_o, 4'b0100);
    check_output("t1_rdata",  bif.col_rdata_o,  32'hDEAD);
    step();
    apply_stimulus(0, 0, 32'h0);

    $display("[TB] pointer-addressed reads with reload");
    bif.ptr_we_i[0] = 1'b1; bif.ptr_base_i[0] = 32'h1000; bif.ptr_stride_i[0] = 32'd4;
    step();
    bif.ptr_we_i[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_col(0, 1, 1, 0, 32'h0, 32'h0);
      apply_stimulus(1, k > 0, 32'h500 + 32'(k));
      bif.ptr_we_i[0] = (k == 2); bif.ptr_base_i[0] = 32'h2000;
      settle();
      check_output("t2_addr", bif.m_addr_o, (k == 3) ? 32'h2000 : 32'h1000 + 32'(4 * k));
      step();
    end
    bif.ptr_we_i[0] = 1'b0;
    drive_col(0, 0, 1, 0, 32'h0, 32'h0);
    apply_stimulus(0, 1, 32'h600);
    step();
    apply_stimulus(0, 0, 32'h0);

    $display("[TB] round-robin with all columns requesting");
    reset_pulse();
    for (int c = 0; c < N_COL; c++) drive_col(c, 1, 1, 1, 32'h40 * 32'(c), 32'h0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, k > 0, 32'h700 + 32'(k));
      settle();
      check_output("t3_order", bif.col_gnt_o, N_COL'(1) << seq[k]);
      step();
    end
    bif.col_req_i = '0;
    apply_stimulus(0, 1, 32'h777);
    step();
    drive_col(3, 1, 1, 1, 32'h30, 32'h0);
    apply_stimulus(1, 0, 32'h0);
    step();
    drive_col(3, 0, 1, 1, 32'h30, 32'h0);
    apply_stimulus(0, 1, 32'h33);
    step();

    $display("[TB] stalled write keeps the port");
    drive_col(1, 1, 0, 1, 32'h40, 32'hCAFE);
    apply_stimulus(0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) drive_col(0, 1, 1, 1, 32'h80, 32'h0);
      settle();
      check_output("t4_addr",  bif.m_addr_o,  32'h40);
      check_output("t4_wdata", bif.m_wdata_o, 32'hCAFE);
      check_output("t4_we",    bif.m_we_o,    1'b1);
      check_output("t4_nogrt", bif.col_gnt_o, 4'b0000);
      step();
    end
    apply_stimulus(1, 0, 32'h0);
    settle();
    check_output("t4_gnt", bif.col_gnt_o, 4'b0010);
    step();
    drive_col(1, 0, 0, 1, 32'h40, 32'hCAFE);
    apply_stimulus(1, 1, 32'hBAD);
    settle();
    check_output("t4_wr_resp", bif.col_rvalid_o, 4'b0000);
    check_output("t4_gnt0",    bif.col_gnt_o,    4'b0001);
    step();
    drive_col(0, 0, 1, 1, 32'h80, 32'h0);
    apply_stimulus(0, 1, 32'h80);
    step();
    apply_stimulus(0, 0, 32'h0);

    $display("[TB] outstanding limit");
    drive_col(2, 1, 1, 1, 32'h200, 32'h0);
    apply_stimulus(1, 0, 32'h0);
    step();
    drive_col(2, 0, 1, 1, 32'h200, 32'h0);
    drive_col(3, 1, 1, 1, 32'h300, 32'h0);
    step();
    drive_col(3, 0, 1, 1, 32'h300, 32'h0);
    drive_col(0, 1, 1, 1, 32'h10, 32'h0);
    settle();
    check_output("t5_full_req", bif.m_req_o,   1'b0);
    check_output("t5_full_gnt", bif.col_gnt_o, 4'b0000);
    step();
    apply_stimulus(1, 1, 32'h22);
    settle();
    check_output("t5_rv2",      bif.col_rvalid_o, 4'b0100);
    check_output("t5_rd2",      bif.col_rdata_o,  32'h22);
    check_output("t5_no_bypass", bif.m_req_o,     1'b0);
    step();
    apply_stimulus(1, 0, 32'h0);
    settle();
    check_output("t5_req_back", bif.m_req_o,   1'b1);
    check_output("t5_gnt0",     bif.col_gnt_o, 4'b0001);
    step();
    drive_col(0, 0, 1, 1, 32'h10, 32'h0);
    apply_stimulus(0, 1, 32'h33);
    settle();
    check_output("t5_rv3", bif.col_rvalid_o, 4'b1000);
    step();
    apply_stimulus(0, 1, 32'h44);
    settle();
    check_output("t5_rv0", bif.col_rvalid_o, 4'b0001);
    step();
    apply_stimulus(0, 0, 32'h0);
    settle();
    check_output("t5_idle_busy", bif.busy_o, 1'b0);

    $display("[TB] spurious response and mid-stall reset");
    step();
    apply_stimulus(0, 1, 32'h99);
    settle();
    check_output("t6_no_rv", bif.col_rvalid_o, 4'b0000);
    step();
    apply_stimulus(0, 0, 32'h0);
    settle();
    check_output("t6_err", bif.err_o, 1'b1);
    step();
    drive_col(1, 1, 1, 1, 32'h50, 32'h0);
    settle();
    check_output("t6_stall_req", bif.m_req_o, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_req",  bif.m_req_o,   1'b0);
    check_output("t6_rst_addr", bif.m_addr_o,  32'h0);
    check_output("t6_rst_gnt",  bif.col_gnt_o, 4'b0000);
    check_output("t6_rst_busy", bif.busy_o,    1'b0);
    check_output("t6_rst_err",  bif.err_o,     1'b0);
    step();
    bif.col_req_i = '0;
    step();
    rst_n = 1'b1;
    apply_stimulus(0, 1, 32'h55);
    step();
    apply_stimulus(0, 0, 32'h0);
    settle();
    check_output("t6_inflight_err", bif.err_o, 1'b1);

    $display("[TB] random traffic");
    reset_pulse();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_COL; c++) begin
        if (!bif.col_req_i[c] || last_gnt[c]) begin
          if ($urandom_range(0, 99) < 55)
            drive_col(c, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom & 32'hFFFC, $urandom);
          else
            bif.col_req_i[c] = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          bif.col_req_i[c] = 1'b0;
        end
        bif.ptr_we_i[c] = ($urandom_range(0, 24) == 0);
        if (bif.ptr_we_i[c]) begin
          bif.ptr_base_i[c]   = $urandom & 32'hFFFF_FFFC;
          bif.ptr_stride_i[c] = 32'(int'($urandom_range(0, 15)) * 4 - 32);
        end
      end
      apply_stimulus(1'($urandom_range(0, 1)),
                     (model_q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 299) == 0),
                     $urandom);
      step();
    end
    bif.col_req_i = '0;
    bif.ptr_we_i  = '0;
    apply_stimulus(0, 0, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_col_mem_arbiter.md
Name: cgra_col_mem_arbiter

Overview:
- Shares one OBI-style memory master port among the N_COL column data ports of the CGRA reconfigurable-cell array.
- Per cycle, each column presents at most one request: read/write, indirect or pointer-addressed.
- The block arbitrates round-robin, generates addresses for non-indirect accesses from per-column auto-incrementing pointers, and routes in-order read responses back to the issuing column.
- Sits between the RC array column ports and the system bus.

Parameters:
N_COL, 4, number of CGRA columns/requesters
DP_WIDTH, 32, data and address width
ARB_OUTSTANDING, 2, maximum issued-but-unanswered transactions (ID FIFO depth, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
col_req_i  in  N_COL  column request; held until col_gnt_o
col_wen_i  in  N_COL  1=read, 0=write
col_ind_i  in  N_COL  1=use col_add_i, 0=use column pointer
col_add_i  in  DP_WIDTH x N_COL  indirect byte address
col_wdata_i  in  DP_WIDTH x N_COL  write data
col_gnt_o  out  N_COL  grant, one-hot or zero
col_rvalid_o  out  N_COL  read data valid, one-hot or zero
col_rdata_o  out  DP_WIDTH  read data broadcast to all columns
ptr_we_i  in  N_COL  load column pointer
ptr_base_i  in  DP_WIDTH x N_COL  pointer load value
ptr_stride_i  in  DP_WIDTH x N_COL  post-increment stride (two's complement)
m_req_o  out  1  master request
m_gnt_i  in  1  master grant
m_we_o  out  1  master write enable (=~wen of winner)
m_be_o  out  4  byte enables, constant 4'hF
m_addr_o  out  DP_WIDTH  master address
m_wdata_o  out  DP_WIDTH  master write data
m_rvalid_i  in  1  master response valid
m_rdata_i  in  DP_WIDTH  master read data
busy_o  out  1  FIFO non-empty or m_req_o high
err_o  out  1  sticky: m_rvalid_i with empty ID FIFO

Behaviour:
- Reset values: all outputs 0; rr_q=0, lock_q=0, ptr_q[*]=0, FIFO empty, err_o=0.
- Winner selection:
  - If lock_q, winner = lock_id_q.
  - Otherwise, winner = first column with col_req_i set, scanning from rr_q upward with wrap-around.
- m_req_o = any col_req_i & (fifo_count < ARB_OUTSTANDING). It is combinational, with zero-cycle latency from col_req_i.
- m_addr_o = col_ind_i[w] ? col_add_i[w] : ptr_q[w].
- m_wdata_o = col_wdata_i[w] when the winner is a write, else 0.
- Address, data and we stay stable while m_req_o is high and not granted:
  - Set lock_q on (m_req_o & ~m_gnt_i).
  - Clear lock_q on grant.
  - Also clear lock_q if col_req_i[lock_id_q] drops (column reset).
- Grant (m_req_o & m_gnt_i):
  - col_gnt_o[w]=1 in the same cycle.
  - rr_q <= (w+1) mod N_COL.
  - Push {w, is_read} into the ID FIFO.
  - If col_ind_i[w]=0, ptr_q[w] <= ptr_q[w] + ptr_stride_i[w] (mod 2^DP_WIDTH).
- ptr_we_i[c] loads ptr_q[c] <= ptr_base_i[c]. A load takes precedence over a same-cycle increment of the same column.
- Response (m_rvalid_i), earliest the cycle after its grant:
  - Pop the FIFO head.
  - If is_read, col_rvalid_o[id]=1 in the same cycle with col_rdata_o=m_rdata_i.
  - Write responses are consumed silently.
- Same-cycle push and pop:
  - Allowed; count unchanged.
  - The full check uses registered count only; a pop does not bypass into the same-cycle push.
- FIFO full: m_req_o=0 and no col_gnt_o until a pop.
- m_rvalid_i with empty FIFO: no col_rvalid_o; err_o <= 1, cleared only by reset.
- Async reset mid-transaction: all state cleared immediately; responses still in flight after reset release raise err_o.

Optional Feature:
- Macro: CGRA_ARB_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (32 x N_COL).
  - Per-column saturating counter, incremented each cycle col_req_i[c] & ~col_gnt_o[c].
  - Cleared by reset or by ptr_we_i[c].
- When undefined: the port and counters are absent; no other behaviour changes.

Decomposition:
- cgra_pkg gains:
  - ARB_OUTSTANDING.
  - typedef cgra_arb_id_t: logic [$clog2(N_COL)-1:0] id plus logic is_read.
  - Reuses N_COL and DP_WIDTH.
- One sub-module, cgra_arb_id_fifo: synchronous FIFO of cgra_arb_id_t, depth ARB_OUTSTANDING, with push/pop/full/empty/count. Async active-low reset.
- Arbitration, pointers and the master mux stay in the top module.

Test Plan:
1. Reset, then col 2 read with ind=1, add=0x100, m_gnt_i=1 immediately, m_rvalid_i next cycle with 0xDEAD → col_gnt_o=4'b0100 in cycle 0; col_rvalid_o=4'b0100 and col_rdata_o=0xDEAD in cycle 1.
2. ptr_we_i[0] with base=0x1000, stride=4; three ind=0 reads by col 0 → m_addr_o 0x1000, 0x1004, 0x1008. Same-cycle ptr_we_i with base 0x2000 on the third grant → ptr_q[0]=0x2000.
3. All columns request continuously with m_gnt_i=1 and immediate rvalid → grant order 0,1,2,3,0. No column is granted twice before all others are granted once.
4. Col 1 write with m_gnt_i held low 3 cycles while col 0 asserts a request → m_addr_o/m_wdata_o/m_we_o stable and winner stays col 1. Col 1 is granted on the 4th cycle. Its write response raises no col_rvalid_o.
5. ARB_OUTSTANDING=2: two grants with no rvalid → m_req_o=0 with a pending request. One rvalid → m_req_o returns the next cycle. Responses return in order to the correct ids.
6. m_rvalid_i pulse with FIFO empty → no col_rvalid_o and err_o=1. Async rst_ni low mid-stall → all outputs 0 immediately.
